// File: rtl/eth_rx_frame_checker_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | eth_rx_frame_checker_if : MAC receive byte stream (no tready)      |
// | Revision 1.0                                                       |
// +-------------------------------------------------------------------+
interface eth_rx_frame_checker_if;
  logic [7:0] rx_axis_mac_tdata;
  logic       rx_axis_mac_tvalid;
  logic       rx_axis_mac_tlast;
  logic       rx_axis_mac_tuser;

  modport master (
    output rx_axis_mac_tdata,
    output rx_axis_mac_tvalid,
    output rx_axis_mac_tlast,
    output rx_axis_mac_tuser
  );

  modport slave (
    input rx_axis_mac_tdata,
    input rx_axis_mac_tvalid,
    input rx_axis_mac_tlast,
    input rx_axis_mac_tuser
  );
endinterface
`default_nettype wire

// File: rtl/eth_rx_frame_checker.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | eth_rx_frame_checker : validates received test frames, counts them |
// | Revision 1.0                                                       |
// +-------------------------------------------------------------------+
module eth_rx_frame_checker #(
  parameter int          FRAME_LEN = 64,
  parameter logic [15:0] EXP_TYPE  = 16'hEBEB,
  parameter logic [47:0] MY_MAC    = 48'h000000000000
) (
  input  wire                          clk_mac,
  input  wire                          rst,
  eth_rx_frame_checker_if.slave        rx,
  input  wire                          clr_counts,
  output logic                         frame_done,
  output logic                         frame_ok,
  output logic [2:0]                   err_code,
  output logic [47:0]                  src_mac,
  output logic [15:0]                  good_count,
  output logic [15:0]                  bad_count
);

  localparam logic [10:0] c_frame_len = 11'(FRAME_LEN);
  localparam logic [10:0] c_last_idx  = 11'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DST     = 3'd1,
    S_SRC     = 3'd2,
    S_TYPE    = 3'd3,
    S_PAYLOAD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic        bcast_q, bcast_d;
  logic        ucast_q, ucast_d;
  logic        type_bad_q, type_bad_d;
  logic        data_bad_q, data_bad_d;
  logic [47:0] src_shadow_q, src_shadow_d;
  logic        pend_q, pend_d;
  logic [2:0]  pend_code_q, pend_code_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [15:0] good_count_q, good_count_d;
  logic [15:0] bad_count_q, bad_count_d;

  logic [10:0] w_cur_idx;
  logic        w_bcast, w_ucast, w_type_bad, w_data_bad;
  logic        w_dst_bad_f, w_type_bad_f, w_len_bad;
  logic        w_good_evt, w_bad_evt;

  function automatic logic [7:0] mac_byte(input logic [2:0] k);
    case (k)
      3'd0:    mac_byte = MY_MAC[47:40];
      3'd1:    mac_byte = MY_MAC[39:32];
      3'd2:    mac_byte = MY_MAC[31:24];
      3'd3:    mac_byte = MY_MAC[23:16];
      3'd4:    mac_byte = MY_MAC[15:8];
      default: mac_byte = MY_MAC[7:0];
    endcase
  endfunction

  always_ff @(posedge clk_mac) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 11'd0;
      bcast_q      <= 1'b0;
      ucast_q      <= 1'b0;
      type_bad_q   <= 1'b0;
      data_bad_q   <= 1'b0;
      src_shadow_q <= 48'd0;
      pend_q       <= 1'b0;
      pend_code_q  <= 3'd0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_code_q   <= 3'd0;
      src_mac_q    <= 48'd0;
      good_count_q <= 16'd0;
      bad_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bcast_q      <= bcast_d;
      ucast_q      <= ucast_d;
      type_bad_q   <= type_bad_d;
      data_bad_q   <= data_bad_d;
      src_shadow_q <= src_shadow_d;
      pend_q       <= pend_d;
      pend_code_q  <= pend_code_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_code_q   <= err_code_d;
      src_mac_q    <= src_mac_d;
      good_count_q <= good_count_d;
      bad_count_q  <= bad_count_d;
    end
  end

  // Beat stage: the first beat of a frame sees freshly cleared flags and idx 0.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bcast_d      = bcast_q;
    ucast_d      = ucast_q;
    type_bad_d   = type_bad_q;
    data_bad_d   = data_bad_q;
    src_shadow_d = src_shadow_q;
    pend_d       = 1'b0;
    pend_code_d  = pend_code_q;

    w_cur_idx    = (state_q == S_IDLE) ? 11'd0 : idx_q;
    w_bcast      = (state_q == S_IDLE) ? 1'b1  : bcast_q;
    w_ucast      = (state_q == S_IDLE) ? 1'b1  : ucast_q;
    w_type_bad   = (state_q == S_IDLE) ? 1'b0  : type_bad_q;
    w_data_bad   = (state_q == S_IDLE) ? 1'b0  : data_bad_q;
    w_dst_bad_f  = 1'b0;
    w_type_bad_f = 1'b0;
    w_len_bad    = 1'b0;

    if (rx.rx_axis_mac_tvalid) begin
      case (state_q)
        S_IDLE, S_DST: begin
          w_bcast = w_bcast & (rx.rx_axis_mac_tdata == 8'hFF);
          w_ucast = w_ucast & (rx.rx_axis_mac_tdata == mac_byte(w_cur_idx[2:0]));
        end
        S_SRC:
          src_shadow_d = {src_shadow_q[39:0], rx.rx_axis_mac_tdata};
        S_TYPE:
          if (rx.rx_axis_mac_tdata != (w_cur_idx[0] ? EXP_TYPE[7:0] : EXP_TYPE[15:8]))
            w_type_bad = 1'b1;
        S_PAYLOAD:
          if (w_cur_idx < c_frame_len && rx.rx_axis_mac_tdata != w_cur_idx[7:0])
            w_data_bad = 1'b1;
        default: ;
      endcase

      bcast_d    = w_bcast;
      ucast_d    = w_ucast;
      type_bad_d = w_type_bad;
      data_bad_d = w_data_bad;

      if (rx.rx_axis_mac_tlast) begin
        w_dst_bad_f  = !(w_bcast || w_ucast) || (w_cur_idx < 11'd5);
        w_type_bad_f = w_type_bad || (w_cur_idx < 11'd13);
        w_len_bad    = (w_cur_idx != c_last_idx);
        pend_d       = 1'b1;
        if (rx.rx_axis_mac_tuser)  pend_code_d = 3'd1;
        else if (w_len_bad)        pend_code_d = 3'd2;
        else if (w_dst_bad_f)      pend_code_d = 3'd3;
        else if (w_type_bad_f)     pend_code_d = 3'd4;
        else if (w_data_bad)       pend_code_d = 3'd5;
        else                       pend_code_d = 3'd0;
        state_d = S_IDLE;
        idx_d   = 11'd0;
      end else begin
        idx_d = (w_cur_idx == 11'h7FF) ? w_cur_idx : w_cur_idx + 11'd1;
        case (state_q)
          S_IDLE:  state_d = S_DST;
          S_DST:   if (w_cur_idx == 11'd5)  state_d = S_SRC;
          S_SRC:   if (w_cur_idx == 11'd11) state_d = S_TYPE;
          S_TYPE:  if (w_cur_idx == 11'd13) state_d = S_PAYLOAD;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Result stage, one edge after the tlast beat; the shadow source stays
  // intact here because a following frame cannot reach idx 6 this soon.
  always_comb begin
    frame_done_d = pend_q;
    frame_ok_d   = frame_ok_q;
    err_code_d   = err_code_q;
    src_mac_d    = src_mac_q;
    w_good_evt   = pend_q && (pend_code_q == 3'd0);
    w_bad_evt    = pend_q && (pend_code_q != 3'd0);

    if (pend_q) begin
      frame_ok_d = w_good_evt;
      err_code_d = pend_code_q;
      if (w_good_evt) src_mac_d = src_shadow_q;
    end

    if (clr_counts)
      good_count_d = {15'd0, w_good_evt};
    else if (w_good_evt && good_count_q != 16'hFFFF)
      good_count_d = good_count_q + 16'd1;
    else
      good_count_d = good_count_q;

    if (clr_counts)
      bad_count_d = {15'd0, w_bad_evt};
    else if (w_bad_evt && bad_count_q != 16'hFFFF)
      bad_count_d = bad_count_q + 16'd1;
    else
      bad_count_d = bad_count_q;
  end

  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign err_code   = err_code_q;
  assign src_mac    = src_mac_q;
  assign good_count = good_count_q;
  assign bad_count  = bad_count_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_checker.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_eth_rx_frame_checker : directed frames against eth_rx_frame_checker |
// | Revision 1.0                                                       |
// +-------------------------------------------------------------------+
module tb_eth_rx_frame_checker;

  logic clk_mac = 1'b0;
  logic rst = 1'b1;
  logic clr_counts = 1'b0;

  always #10 clk_mac = ~clk_mac;

  eth_rx_frame_checker_if rx_if ();

  logic        frame_done, frame_ok;
  logic [2:0]  err_code;
  logic [47:0] src_mac;
  logic [15:0] good_count, bad_count;

  logic        frame_done_1, frame_ok_1;
  logic [2:0]  err_code_1;
  logic [47:0] src_mac_1;
  logic [15:0] good_count_1, bad_count_1;

  eth_rx_frame_checker #(.FRAME_LEN(64), .EXP_TYPE(16'hEBEB), .MY_MAC(48'h000000000000)) u_dut (
    .clk_mac    (clk_mac),
    .rst        (rst),
    .rx         (rx_if),
    .clr_counts (clr_counts),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_code   (err_code),
    .src_mac    (src_mac),
    .good_count (good_count),
    .bad_count  (bad_count)
  );

  eth_rx_frame_checker #(.FRAME_LEN(64), .EXP_TYPE(16'hEBEB), .MY_MAC(48'h020000000001)) u_dut_uc (
    .clk_mac    (clk_mac),
    .rst        (rst),
    .rx         (rx_if),
    .clr_counts (clr_counts),
    .frame_done (frame_done_1),
    .frame_ok   (frame_ok_1),
    .err_code   (err_code_1),
    .src_mac    (src_mac_1),
    .good_count (good_count_1),
    .bad_count  (bad_count_1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [7:0] frm [0:127];

  localparam logic [47:0] c_src = 48'h112233445566;

  always @(negedge clk_mac) if (frame_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_good();
    for (int i = 0; i < 128; i++) frm[i] = 8'(i);
    for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
    frm[6] = 8'h11; frm[7] = 8'h22; frm[8]  = 8'h33;
    frm[9] = 8'h44; frm[10] = 8'h55; frm[11] = 8'h66;
    frm[12] = 8'hEB; frm[13] = 8'hEB;
  endtask

  task automatic beat(input logic [7:0] d, input logic last, input logic user);
    @(negedge clk_mac);
    rx_if.rx_axis_mac_tvalid = 1'b1;
    rx_if.rx_axis_mac_tdata  = d;
    rx_if.rx_axis_mac_tlast  = last;
    rx_if.rx_axis_mac_tuser  = user;
  endtask

  task automatic idle();
    @(negedge clk_mac);
    rx_if.rx_axis_mac_tvalid = 1'b0;
    rx_if.rx_axis_mac_tlast  = 1'b0;
    rx_if.rx_axis_mac_tuser  = 1'b0;
  endtask

  // Sends frm[first..n-1]; returns one negedge after the frame_done pulse.
  task automatic send_frame(input int first, input int n, input bit user, input int gap, input bit clr);
    for (int i = first; i < n; i++) begin
      beat(frm[i], i == n - 1, (i == n - 1) ? user : 1'b0);
      if (i != n - 1) repeat (gap) idle();
    end
    idle();
    clr_counts = clr;
    check("done_early", {63'd0, frame_done}, 64'd0);
    @(negedge clk_mac);
    clr_counts = 1'b0;
    check("done_pulse", {63'd0, frame_done}, 64'd1);
    @(negedge clk_mac);
    check("done_drop", {63'd0, frame_done}, 64'd0);
  endtask

  task automatic expect_res(input string tag, input logic [2:0] code, input logic ok,
                            input logic [15:0] good, input logic [15:0] bad, input logic [47:0] src);
    check({tag, "_code"}, {61'd0, err_code}, {61'd0, code});
    check({tag, "_ok"},   {63'd0, frame_ok}, {63'd0, ok});
    check({tag, "_good"}, {48'd0, good_count}, {48'd0, good});
    check({tag, "_bad"},  {48'd0, bad_count}, {48'd0, bad});
    check({tag, "_src"},  {16'd0, src_mac}, {16'd0, src});
  endtask

  initial begin
    int d0;
    rx_if.rx_axis_mac_tvalid = 1'b0;
    rx_if.rx_axis_mac_tdata  = 8'h00;
    rx_if.rx_axis_mac_tlast  = 1'b0;
    rx_if.rx_axis_mac_tuser  = 1'b0;
    repeat (3) @(negedge clk_mac);
    rst = 1'b0;
    check("rst_done", {63'd0, frame_done}, 64'd0);
    expect_res("rst", 3'd0, 1'b0, 16'd0, 16'd0, 48'd0);

    build_good();
    send_frame(0, 64, 1'b0, 3, 1'b0);
    expect_res("good", 3'd0, 1'b1, 16'd1, 16'd0, c_src);

    frm[6] = 8'hAA;
    send_frame(0, 64, 1'b1, 0, 1'b0);
    expect_res("fcs", 3'd1, 1'b0, 16'd1, 16'd1, c_src);

    build_good(); frm[20] = 8'h00;
    send_frame(0, 64, 1'b1, 1, 1'b0);
    expect_res("fcs_prio", 3'd1, 1'b0, 16'd1, 16'd2, c_src);

    build_good();
    send_frame(0, 41, 1'b0, 0, 1'b0);
    expect_res("len41", 3'd2, 1'b0, 16'd1, 16'd3, c_src);

    for (int i = 64; i < 70; i++) frm[i] = 8'h00;
    send_frame(0, 70, 1'b0, 0, 1'b0);
    expect_res("len70", 3'd2, 1'b0, 16'd1, 16'd4, c_src);

    build_good();
    send_frame(0, 1, 1'b0, 0, 1'b0);
    expect_res("len1", 3'd2, 1'b0, 16'd1, 16'd5, c_src);

    frm[0] = 8'h02; frm[1] = 8'h00; frm[2] = 8'h00;
    frm[3] = 8'h00; frm[4] = 8'h00; frm[5] = 8'h01;
    send_frame(0, 64, 1'b0, 0, 1'b0);
    expect_res("dst", 3'd3, 1'b0, 16'd1, 16'd6, c_src);
    check("uc_code", {61'd0, err_code_1}, 64'd0);
    check("uc_ok",   {63'd0, frame_ok_1}, 64'd1);
    check("uc_good", {48'd0, good_count_1}, 64'd2);
    check("uc_src",  {16'd0, src_mac_1}, {16'd0, c_src});

    build_good(); frm[12] = 8'h08; frm[13] = 8'h00;
    send_frame(0, 64, 1'b0, 0, 1'b0);
    expect_res("type", 3'd4, 1'b0, 16'd1, 16'd7, c_src);

    build_good(); frm[30] = 8'h00;
    send_frame(0, 64, 1'b0, 0, 1'b0);
    expect_res("data", 3'd5, 1'b0, 16'd1, 16'd8, c_src);

    build_good();
    send_frame(0, 64, 1'b0, 0, 1'b1);
    expect_res("clr", 3'd0, 1'b1, 16'd1, 16'd0, c_src);

    d0 = done_cnt;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 64; i++) beat(frm[i], i == 63, 1'b0);
    repeat (4) idle();
    check("b2b_pulses", 64'(done_cnt - d0), 64'd2);
    expect_res("b2b", 3'd0, 1'b1, 16'd3, 16'd0, c_src);

    for (int i = 0; i < 65535; i++) beat(8'h00, 1'b1, 1'b0);
    repeat (4) idle();
    check("sat_fill", {48'd0, bad_count}, 64'hFFFF);
    frm[0] = 8'h00;
    send_frame(0, 1, 1'b0, 0, 1'b0);
    expect_res("sat", 3'd2, 1'b0, 16'd3, 16'hFFFF, c_src);

    build_good();
    for (int i = 0; i < 20; i++) beat(frm[i], 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk_mac);
    rst = 1'b0;
    check("mid_rst_done", {63'd0, frame_done}, 64'd0);
    expect_res("mid_rst", 3'd0, 1'b0, 16'd0, 16'd0, 48'd0);
    send_frame(20, 64, 1'b0, 0, 1'b0);
    expect_res("resume", 3'd2, 1'b0, 16'd0, 16'd1, 48'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_rx_frame_checker.md
# eth_rx_frame_checker

Receive-side checker for the Ethernet MAC's `rx_axis_mac_*` byte stream in the clk_mac domain. It is the counterpart of the fixed 64-byte test-frame transmitter. Each received frame is validated against the expected test pattern: destination, ethertype, incrementing payload, length and MAC error flag. The block keeps saturating good/bad frame counters and reports a per-frame error code, which can be routed to LEDs or read by a host.

## Interface
- `FRAME_LEN`, 64: expected frame length in bytes, from destination MAC through the last payload byte. FCS is excluded, since the MAC strips it. Legal range is 15..2047.
- `EXP_TYPE`, 16'hEBEB: expected ethertype at bytes 12..13, big-endian.
- `MY_MAC`, 48'h000000000000: accepted unicast destination. Broadcast ff:ff:ff:ff:ff:ff is always accepted.
- `clk_mac`  in  1  MAC clock, 50 MHz. All logic runs on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_axis_mac_tdata`  in  8  received byte.
- `rx_axis_mac_tvalid`  in  1  byte valid. There is no tready; the checker accepts every valid beat.
- `rx_axis_mac_tlast`  in  1  last byte of the frame.
- `rx_axis_mac_tuser`  in  1  MAC error flag (bad FCS, rxerr). It is sampled only on the tlast beat.
- `clr_counts`  in  1  synchronous pulse that zeroes both counters.
- `frame_done`  out  1  one-cycle pulse per completed frame.
- `frame_ok`  out  1  result of the most recent frame. Valid from `frame_done` onward.
- `err_code`  out  3  error code of the most recent frame.
- `src_mac`  out  48  source MAC (bytes 6..11) of the most recent good frame.
- `good_count`  out  16  number of good frames, saturating at 16'hFFFF.
- `bad_count`  out  16  number of bad frames, saturating at 16'hFFFF.

## Operation
- A beat is any cycle with `rx_axis_mac_tvalid`=1. Cycles without tvalid change nothing. Gaps of any length between beats are legal; RMII delivers one byte per 4 cycles.
- `idx` is an 11-bit byte index that saturates at 2047.
  - It is 0 on the first beat of a frame and increments on each subsequent beat.
  - It returns to 0 after a tlast beat.
- State machine, with `idx` tracked inside each state:
  - **IDLE** (no frame in progress): the first beat enters DST.
  - **DST** (idx 0..5)
  - **SRC** (idx 6..11)
  - **TYPE** (idx 12..13)
  - **PAYLOAD** (idx ≥ 14)
  - A tlast beat in any state, including the first beat, goes through evaluation and then back to IDLE.
- Sticky per-frame flags are cleared on the first beat of each frame:
  - **dst_bad**: the byte is not 8'hFF, which clears the broadcast candidate, and the byte differs from `MY_MAC` byte idx (MSB first), which clears the unicast candidate. The flag is set if both candidates are cleared by the end of DST.
  - **type_bad**: the byte differs from `EXP_TYPE` byte idx−12.
  - **data_bad**: for 14 ≤ idx < `FRAME_LEN`, `tdata` ≠ idx[7:0]. Bytes at idx ≥ `FRAME_LEN` are not data-checked.
  - Source bytes are shifted into a shadow register.
- Short frames: a frame that ends before idx 5 sets dst_bad. A frame that ends before idx 13 sets type_bad.
- Evaluation on the tlast beat:
  - `len_bad` = (idx ≠ `FRAME_LEN`−1).
  - `fcs_bad` = `tuser`.
- `err_code` is assigned by priority: 1 FCS, 2 LEN, 3 DST, 4 TYPE, 5 DATA, 0 OK.
- On OK: `frame_ok`=1, `good_count` increments (saturating), and `src_mac` takes the shadow value.
- On any error: `frame_ok`=0, `bad_count` increments (saturating), and `src_mac` holds its previous value.
- `clr_counts` takes priority over the count value:
  - counter ← 0, or 1 if that counter increments on the same edge.
  - `clr_counts` does not affect `err_code`, `frame_ok` or `src_mac`.

## Timing
- Reset values:
  - `frame_done`=0, `frame_ok`=0, `err_code`=0, `src_mac`=0.
  - `good_count`=0, `bad_count`=0.
  - State is IDLE, `idx`=0, all flags are clear.
- Latency: the tlast beat is sampled at edge N. At edge N+1, `frame_done`=1 and `frame_ok`, `err_code`, `src_mac` and the counters update together. `frame_done` returns to 0 at edge N+2.
- Back-to-back frames are supported: a beat on the cycle right after tlast starts a new frame while `frame_done` is pulsing.
- Reset mid-frame: the block returns to IDLE immediately. Any remaining beats of the interrupted frame are checked as a new frame and normally report LEN or DST. No beat is dropped silently.
- No combinational path exists from inputs to outputs; every output is registered.

## Test plan
- **Good frame**: 64 beats with 6×FF, 6×00, EB EB, then bytes 14..63 = 0x0E..0x3F, tlast on beat 63, tuser=0, with 3 idle cycles between beats → `frame_done` for 1 cycle, 1 edge after tlast, with `err_code`=0, `good_count`=1, `src_mac`=0.
- **FCS error**: the same frame with tuser=1 on tlast → `err_code`=1, `bad_count`=1, `src_mac` unchanged. Repeat with a corrupted payload byte as well → `err_code` is still 1 (priority).
- **Length errors**:
  - tlast on beat 40 → `err_code`=2.
  - 70-byte frame with bytes 64..69 = 0x00 → `err_code`=2 and no DATA error.
  - single-beat frame (tlast on the first beat) → `err_code`=2.
- **Destination, type and data**:
  - Destination 02:00:00:00:00:01 with `MY_MAC`=0 → 3.
  - Ethertype 0x0800 → 4.
  - byte 30 = 0x00 → 5.
  - Destination equal to `MY_MAC`=02:00:00:00:00:01 → 0.
- **Counters**:
  - Preload `bad_count` to FFFF through 65535 bad frames (or a forced value) and send one more bad frame → it stays FFFF.
  - Assert `clr_counts` on the `frame_done` edge of a good frame → `good_count`=1 and `bad_count`=0.
- **Back-to-back and reset**:
  - Two good frames with zero gap → two `frame_done` pulses, `good_count`=2.
  - Assert rst at beat 20 of a frame, then stream the remaining beats → all outputs are 0 after reset, followed by one bad frame with `err_code`=2.
